// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the requester/UART side.
interface uart_tx_arbiter_if #(
    parameter int F_SIZE  = 8,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*F_SIZE-1:0] data_i;
    logic [NUM_REQ-1:0]        ack_o;
    logic [NUM_REQ-1:0]        done_o;
    logic                      busy_o;
    logic [IDX_W-1:0]          grant_idx_o;
    logic                      uart_start_o;
    logic [F_SIZE-1:0]         uart_data_o;
    logic                      uart_end_i;

    modport slave (
        input  req_i, data_i, uart_end_i,
        output ack_o, done_o, busy_o, grant_idx_o, uart_start_o, uart_data_o
    );

    modport master (
        output req_i, data_i, uart_end_i,
        input  ack_o, done_o, busy_o, grant_idx_o, uart_start_o, uart_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one single-frame UART transmitter among NUM_REQ requesters.
// Captures the winner's data in IDLE, pulses start, waits for end-of-frame, then forces an idle gap.
module uart_tx_arbiter #(
    parameter int F_SIZE     = 8,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [F_SIZE-1:0]  data_q;
    logic [7:0]         gap_cnt;

    logic               any_req;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   winner_nxt;
    logic               gap_last;
    logic               capture;

    // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        any_req  = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any_req && bus.req_i[cand_idx]) begin
                any_req = 1'b1;
                winner  = cand_idx;
            end
        end
    end

    assign winner_nxt = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    assign capture    = (state == IDLE) && any_req;
    assign gap_last   = ({1'b0, gap_cnt} + 9'd1) == 9'(GAP_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = SEND;
            SEND: state_nxt = WAIT;
            WAIT: if (bus.uart_end_i) state_nxt = DONE;
            DONE: state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame data is only loaded at the IDLE grant edge, so it stays frozen for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            grant_idx <= '0;
            data_q    <= '0;
            gap_cnt   <= '0;
        end else begin
            if (capture) begin
                data_q    <= bus.data_i[winner*F_SIZE +: F_SIZE];
                grant_idx <= winner;
                ptr       <= winner_nxt;
            end
            if (state == GAP) begin
                gap_cnt <= gap_last ? 8'd0 : gap_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        bus.ack_o        = '0;
        bus.done_o       = '0;
        bus.uart_start_o = 1'b0;
        bus.busy_o       = (state != IDLE);
        case (state)
            SEND: begin
                bus.ack_o[grant_idx] = 1'b1;
                bus.uart_start_o     = 1'b1;
            end
            DONE: bus.done_o[grant_idx] = 1'b1;
            default: ;
        endcase
    end

    assign bus.grant_idx_o = grant_idx;
    assign bus.uart_data_o = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of request bursts with a scoreboard of expected grants,
// plus hand sequences for dropped requests, stuck end, async reset mid-frame and zero gap.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int FS = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.F_SIZE(FS), .NUM_REQ(NR), .IDX_W(IW)) ifa ();
  uart_tx_arbiter_if #(.F_SIZE(FS), .NUM_REQ(NR), .IDX_W(IW)) ifb ();

  uart_tx_arbiter #(.F_SIZE(FS), .NUM_REQ(NR), .GAP_CYCLES(2), .IDX_W(IW)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  uart_tx_arbiter #(.F_SIZE(FS), .NUM_REQ(NR), .GAP_CYCLES(0), .IDX_W(IW)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic [IW-1:0] idx;
    logic [FS-1:0] data;
  } exp_t;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*FS-1:0] data;
    int               n;
    logic [15:0]      order;   // nibble i = index of the i-th expected grant
  } vec_t;

  vec_t vecs[6];
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit            in_frame = 0;
  bit            hold_ok = 1;
  bit            lat_chk = 1;
  bit            proto_ok = 1;
  bit            stall_a = 0;
  logic [IW-1:0] cur_idx = '0;
  logic [FS-1:0] cur_data = '0;
  int            start_cyc = 0;
  int            done_cyc = 0;
  int            n_done = 0;
  int            starts[$];
  int            ua_cnt = 0;
  int            ub_cnt = 0;
  int            b_start[$];
  int            b_done[$];
  logic [IW-1:0] b_grant[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs at the falling edge, then update requesters and UART models.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if ($countones(ifa.ack_o) > 1 || $countones(ifa.done_o) > 1 ||
        (|ifa.ack_o && |ifa.done_o) || (ifa.uart_start_o != |ifa.ack_o))
      proto_ok = 0;
    if (|ifa.ack_o) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ifa.ack_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack", 32'(ifa.ack_o), 32'd1 << e.idx);
        check("start", 32'(ifa.uart_start_o), 32'd1);
        check("grant_idx", 32'(ifa.grant_idx_o), 32'(e.idx));
        check("capture", 32'(ifa.uart_data_o), 32'(e.data));
        in_frame  = 1;
        hold_ok   = 1;
        cur_idx   = e.idx;
        cur_data  = e.data;
        start_cyc = cyc;
        starts.push_back(cyc);
      end
      for (int k = 0; k < NR; k++) begin
        if (ifa.ack_o[k]) begin
          ifa.req_i[k] = 1'b0;
          ifa.data_i[k*FS +: FS] = 8'hFF;
        end
      end
    end else if (in_frame && ifa.uart_data_o !== cur_data) begin
      hold_ok = 0;
    end
    if (|ifa.done_o) begin
      if (!in_frame) begin
        check("unexpected_done", 32'(ifa.done_o), 32'd0);
      end else begin
        check("done", 32'(ifa.done_o), 32'd1 << cur_idx);
        check("data_hold", 32'(hold_ok), 32'd1);
        if (lat_chk) check("done_latency", 32'(cyc - start_cyc), 32'd11);
        in_frame = 0;
        n_done++;
        done_cyc = cyc;
      end
    end
    if (ifa.uart_start_o) ua_cnt = 11;
    else if (ua_cnt > 0) ua_cnt--;
    if (!stall_a) ifa.uart_end_i = (ua_cnt == 1);

    if (ifb.uart_start_o) begin
      b_start.push_back(cyc);
      b_grant.push_back(ifb.grant_idx_o);
    end
    if (|ifb.done_o) b_done.push_back(cyc);
    if (ifb.uart_start_o) ub_cnt = 11;
    else if (ub_cnt > 0) ub_cnt--;
    ifb.uart_end_i = (ub_cnt == 1);
  endtask

  task automatic wait_dones(input int n);
    int budget = 0;
    while (n_done < n && budget < 400) begin
      tick();
      budget++;
    end
    check("frames_completed", 32'(n_done), 32'(n));
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (ifa.busy_o && budget < 50) begin
      tick();
      budget++;
    end
    check("idle_after_done", 32'(cyc - done_cyc), 32'd3);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic push_exp(input logic [IW-1:0] idx, input logic [FS-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic run_burst(input vec_t v);
    int t0;
    ifa.data_i = v.data;
    ifa.req_i  = v.req;
    t0 = cyc;
    for (int i = 0; i < v.n; i++) begin
      logic [IW-1:0] idx;
      idx = IW'(v.order[i*4 +: 4]);
      push_exp(idx, v.data[idx*FS +: FS]);
    end
    starts.delete();
    n_done = 0;
    wait_dones(v.n);
    if (starts.size() > 0) check("first_start_latency", 32'(starts[0] - t0), 32'd1);
    for (int i = 1; i < starts.size(); i++)
      check("start_spacing", 32'(starts[i] - starts[i-1]), 32'd15);
    wait_idle();
  endtask

  initial begin
    int budget;
    vecs[0] = '{req: 4'b1111, data: 32'hA3A2_A1A0, n: 4, order: 16'h3210};
    vecs[1] = '{req: 4'b0001, data: 32'h0000_0055, n: 1, order: 16'h0000};
    vecs[2] = '{req: 4'b0100, data: 32'h0022_0000, n: 1, order: 16'h0002};
    vecs[3] = '{req: 4'b1001, data: 32'h1300_0010, n: 2, order: 16'h0003};
    vecs[4] = '{req: 4'b1010, data: 32'h3100_2100, n: 2, order: 16'h0031};
    vecs[5] = '{req: 4'b0110, data: 32'h0042_3200, n: 2, order: 16'h0021};

    ifa.req_i = '0; ifa.data_i = '0; ifa.uart_end_i = 1'b0;
    ifb.req_i = '0; ifb.data_i = '0; ifb.uart_end_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_ack", 32'(ifa.ack_o), 32'd0);
    check("rst_done", 32'(ifa.done_o), 32'd0);
    check("rst_busy", 32'(ifa.busy_o), 32'd0);
    check("rst_start", 32'(ifa.uart_start_o), 32'd0);
    check("rst_data", 32'(ifa.uart_data_o), 32'd0);
    check("rst_grant", 32'(ifa.grant_idx_o), 32'd0);
    rst = 1'b0;
    ifb.req_i  = 4'b0011;
    ifb.data_i = 32'h0000_B1B0;

    for (int v = 0; v < 6; v++) run_burst(vecs[v]);

    // A request raised and dropped while another frame is in flight is never granted.
    n_done = 0;
    ifa.data_i = 32'h0077_0066;
    ifa.req_i  = 4'b0001;
    push_exp(2'd0, 8'h66);
    for (int i = 0; i < 4; i++) tick();
    ifa.req_i[2] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ifa.req_i[2] = 1'b0;
    wait_dones(1);
    wait_idle();

    // Stuck-low end keeps the block waiting; a late end then completes the frame.
    n_done  = 0;
    stall_a = 1;
    lat_chk = 0;
    ifa.uart_end_i = 1'b0;
    ifa.data_i = 32'h0088_0000;
    ifa.req_i  = 4'b0100;
    push_exp(2'd2, 8'h88);
    for (int i = 0; i < 40; i++) tick();
    check("stuck_busy", 32'(ifa.busy_o), 32'd1);
    check("stuck_no_done", 32'(n_done), 32'd0);
    check("stuck_acked", 32'(sb.size()), 32'd0);
    ifa.uart_end_i = 1'b1;
    tick();
    ifa.uart_end_i = 1'b0;
    stall_a = 0;
    wait_dones(1);
    lat_chk = 1;
    wait_idle();

    // Async reset during WAIT aborts the frame with no done.
    n_done = 0;
    ifa.data_i = 32'h0000_0055;
    ifa.req_i  = 4'b0001;
    push_exp(2'd0, 8'h55);
    budget = 0;
    while (starts.size() == 0 || in_frame == 0) begin
      starts.delete();
      tick();
      budget++;
      if (budget > 10) break;
    end
    check("pre_reset_ack", 32'(in_frame), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", 32'(ifa.ack_o), 32'd0);
    check("arst_done", 32'(ifa.done_o), 32'd0);
    check("arst_busy", 32'(ifa.busy_o), 32'd0);
    check("arst_start", 32'(ifa.uart_start_o), 32'd0);
    check("arst_data", 32'(ifa.uart_data_o), 32'd0);
    check("arst_grant", 32'(ifa.grant_idx_o), 32'd0);
    in_frame = 0;
    ua_cnt = 0;
    ub_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("no_done_after_reset", 32'(n_done), 32'd0);

    // Spurious end while idle is ignored.
    stall_a = 1;
    ifa.uart_end_i = 1'b1;
    tick();
    ifa.uart_end_i = 1'b0;
    tick();
    check("spurious_end_busy", 32'(ifa.busy_o), 32'd0);
    check("spurious_end_start", 32'(ifa.uart_start_o), 32'd0);
    stall_a = 0;

    // Pointer restarts at 0 after reset: requester 0 wins over 1.
    n_done = 0;
    done_cyc = cyc;
    ifa.data_i = 32'h0000_C1C0;
    ifa.req_i  = 4'b0011;
    push_exp(2'd0, 8'hC0);
    push_exp(2'd1, 8'hC1);
    wait_dones(2);
    wait_idle();

    // Zero-gap instance with both requests held.
    check("b_records", 32'(b_start.size() >= 2 && b_done.size() >= 1), 32'd1);
    if (b_start.size() >= 2 && b_done.size() >= 1) begin
      check("b_first_grant", 32'(b_grant[0]), 32'd0);
      check("b_second_grant", 32'(b_grant[1]), 32'd1);
      check("b_zero_gap", 32'(b_start[1] - b_done[0]), 32'd2);
    end

    check("onehot_protocol", 32'(proto_ok), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
